controle_cronometro: RTL and testbench

Stopwatch controller. Takes the three raw board push-buttons (active-low) and sequences the tenth-of-second counter by driving its 3-bit `estado` mode input.
- Each button is debounced and edge-detected.
- A 4-state mode machine runs on the resulting press events.
- On a lap request, the current running total is captured into a lap register.
- Sits between the board keys and the counter; `estado` drives the counter directly, and the counter's running total feeds back in.

---
 rtl/cronometro_pkg.sv | 23 ++
 rtl/debouncer_botao.sv | 71 +++++++
 rtl/controle_cronometro.sv | 138 +++++++++++++
 tb/tb_controle_cronometro.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cronometro_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cronometro_pkg
//  Description : Shared definitions for the stopwatch: counter mode
//                encodings and the running-total width and limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cronometro_pkg;

    // Running-total width and the largest value the counter produces
    localparam int NUM_W   = 15;
    localparam int NUM_MAX = 10000;

    // Mode driven to the counter
    typedef enum logic [2:0] {
        EST_ZERA    = 3'd0,
        EST_CONTA   = 3'd1,
        EST_CONGELA = 3'd2,
        EST_PARADO  = 3'd3
    } estado_t;

endpackage : cronometro_pkg
`default_nettype wire

// File: rtl/debouncer_botao.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_botao
//  Description : Push-button front end. It synchronises the raw active-low
//                key, accepts a new level only after a long enough run of
//                disagreeing samples, and emits a one-cycle pulse when the
//                accepted level falls (press). A release produces no pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_botao #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    // The counter has to hold DEBOUNCE_CYCLES itself
    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count completed disagreement cycles; flip the level once the count has
    // reached DEBOUNCE_CYCLES and the sample still disagrees, any agreement restarts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered falling-edge detector on the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
        end
    end

    assign press = r_press;

endmodule : debouncer_botao
`default_nettype wire

// File: rtl/controle_cronometro.sv
`default_nettype none
// ============================================================================
//  Module      : controle_cronometro
//  Description : Stopwatch controller. Debounces the three board keys, runs
//                the ZERA/CONTA/CONGELA/PARADO mode machine on the press
//                pulses, captures lap values and drives the counter mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_cronometro
    import cronometro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CONGELA_MAX     = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start_n,
    input  logic             key_parcial_n,
    input  logic             key_zera_n,
    input  logic [NUM_W-1:0] num_total,
    output logic [2:0]       estado,
    output logic [NUM_W-1:0] parcial,
    output logic             parcial_valido,
    output logic             evento
);

    // Timer only needs to reach CONGELA_MAX-1
    localparam int                 c_tmr_w    = (CONGELA_MAX > 1) ? $clog2(CONGELA_MAX) : 1;
    localparam int                 c_tmr_lim  = (CONGELA_MAX > 0) ? (CONGELA_MAX - 1) : 0;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_tmr_lim);
    localparam bit                 c_tmr_on   = (CONGELA_MAX != 0);

    logic             w_start;
    logic             w_parcial;
    logic             w_zera;
    logic             w_timeout;
    logic             w_captura;
    logic             w_limpa;
    estado_t          w_prox;

    estado_t          r_estado;
    logic [NUM_W-1:0] r_parcial;
    logic             r_valido;
    logic             r_evento;
    logic [c_tmr_w-1:0] r_timer;

    debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_start_n),
        .press (w_start)
    );

    debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_parcial (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_parcial_n),
        .press (w_parcial)
    );

    debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_zera (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_zera_n),
        .press (w_zera)
    );

    assign w_timeout = c_tmr_on && (r_timer == c_tmr_last);

    // Next mode from press pulses: zera beats start beats parcial, presses
    // beat the CONGELA timeout
    always_comb begin
        w_prox    = r_estado;
        w_captura = 1'b0;
        w_limpa   = 1'b0;
        if (w_zera) begin
            w_prox  = EST_ZERA;
            w_limpa = 1'b1;
        end else begin
            case (r_estado)
                EST_ZERA: begin
                    if (w_start) w_prox = EST_CONTA;
                end
                EST_CONTA: begin
                    if (w_start) begin
                        w_prox = EST_PARADO;
                    end else if (w_parcial) begin
                        w_prox    = EST_CONGELA;
                        w_captura = 1'b1;
                    end
                end
                EST_CONGELA: begin
                    if (w_start)        w_prox = EST_PARADO;
                    else if (w_parcial) w_prox = EST_CONTA;
                    else if (w_timeout) w_prox = EST_CONTA;
                end
                EST_PARADO: begin
                    if (w_start) w_prox = EST_CONTA;
                end
                default: w_prox = EST_ZERA;
            endcase
        end
    end

    // Mode register, lap register, change pulse and CONGELA residence timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado  <= EST_ZERA;
            r_parcial <= '0;
            r_valido  <= 1'b0;
            r_evento  <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_estado <= w_prox;
            r_evento <= (w_prox != r_estado);
            if (w_limpa) begin
                r_parcial <= '0;
                r_valido  <= 1'b0;
            end else if (w_captura) begin
                r_parcial <= num_total;
                r_valido  <= 1'b1;
            end
            // Timer starts from zero on each entry into CONGELA
            if ((r_estado == EST_CONGELA) && (w_prox == EST_CONGELA)) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign estado         = r_estado;
    assign parcial        = r_parcial;
    assign parcial_valido = r_valido;
    assign evento         = r_evento;

endmodule : controle_cronometro
`default_nettype wire

// File: tb/tb_controle_cronometro.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_cronometro
//  Description : Self-checking bench for the stopwatch controller. A
//                behavioural model built from key sample histories and a
//                mode table predicts every output each cycle; directed
//                scenarios are followed by randomised key traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_cronometro;

    localparam int D     = 4;
    localparam int MAXC  = 20;
    localparam int NCYC  = 8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_start_n = 1'b1;
    logic        key_parcial_n = 1'b1;
    logic        key_zera_n = 1'b1;
    logic [14:0] num_total = '0;
    logic [2:0]  estado;
    logic [14:0] parcial;
    logic        parcial_valido;
    logic        evento;

    controle_cronometro #(
        .DEBOUNCE_CYCLES (D),
        .CONGELA_MAX     (MAXC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_start_n    (key_start_n),
        .key_parcial_n  (key_parcial_n),
        .key_zera_n     (key_zera_n),
        .num_total      (num_total),
        .estado         (estado),
        .parcial        (parcial),
        .parcial_valido (parcial_valido),
        .evento         (evento)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;

    // Model: raw key samples, accepted levels and press pulses per edge
    bit keyh [3][NCYC];
    bit lvlh [3][NCYC];
    bit prsh [3][NCYC];
    int t = -1;
    int rst_edge = -1;
    int m_mode = 0;
    logic [14:0] m_parcial = '0;
    bit m_valid = 1'b0;
    bit m_evt = 1'b0;
    int m_entry = 0;

    // Key sample seen by the debouncer; anything at or before a reset reads as released
    function automatic bit samp(int b, int e);
        if (e < 0 || e <= rst_edge) return 1'b1;
        return keyh[b][e];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_edge(bit r, bit ks, bit kp, bit kz, logic [14:0] num);
        bit sp, pp, zp, old, all_diff;
        int prev;
        t++;
        if (t >= NCYC) begin
            $display("FAIL model_budget: edge %0d exceeds history size %0d", t, NCYC);
            $fatal(1, "history exhausted");
        end
        keyh[0][t] = ks;
        keyh[1][t] = kp;
        keyh[2][t] = kz;
        if (!r) begin
            rst_edge = t;
            for (int b = 0; b < 3; b++) begin
                lvlh[b][t] = 1'b1;
                prsh[b][t] = 1'b0;
            end
            m_mode = 0; m_parcial = '0; m_valid = 1'b0; m_evt = 1'b0;
            return;
        end
        sp = prsh[0][t-1];
        pp = prsh[1][t-1];
        zp = prsh[2][t-1];
        prev = m_mode;
        if (zp) begin
            m_mode = 0; m_parcial = '0; m_valid = 1'b0;
        end else if (m_mode == 0) begin
            if (sp) m_mode = 1;
        end else if (m_mode == 1) begin
            if (sp) m_mode = 3;
            else if (pp) begin
                m_mode = 2; m_parcial = num; m_valid = 1'b1; m_entry = t;
            end
        end else if (m_mode == 2) begin
            if (sp) m_mode = 3;
            else if (pp || (t - m_entry == MAXC)) m_mode = 1;
        end else begin
            if (sp) m_mode = 1;
        end
        m_evt = (m_mode != prev);
        for (int b = 0; b < 3; b++) begin
            old = lvlh[b][t-1];
            all_diff = 1'b1;
            for (int e = t - D - 2; e <= t - 2; e++)
                if (samp(b, e) == old) all_diff = 1'b0;
            lvlh[b][t] = all_diff ? ~old : old;
            prsh[b][t] = (t - 1 > rst_edge) && lvlh[b][t-2] && !lvlh[b][t-1];
        end
    endtask

    // One clock: inputs already driven; model follows the edge, outputs checked 1 ns later
    task automatic step();
        @(posedge clk);
        model_edge(rst_n, key_start_n, key_parcial_n, key_zera_n, num_total);
        #1;
        check("estado", 32'(estado), 32'(m_mode));
        check("parcial", 32'(parcial), 32'(m_parcial));
        check("parcial_valido", 32'(parcial_valido), 32'(m_valid));
        check("evento", 32'(evento), 32'(m_evt));
        if (evento === 1'b1) ev_cnt++;
        @(negedge clk);
    endtask

    task automatic cycles(int n);
        repeat (n) step();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Hold the selected keys (bit0 start, bit1 parcial, bit2 zera) long enough for one press
    task automatic press_keys(bit [2:0] sel);
        if (sel[0]) key_start_n = 1'b0;
        if (sel[1]) key_parcial_n = 1'b0;
        if (sel[2]) key_zera_n = 1'b0;
        cycles(D + 6);
        key_start_n = 1'b1; key_parcial_n = 1'b1; key_zera_n = 1'b1;
        cycles(D + 4);
    endtask

    int hold [3];
    bit kv [3];

    initial begin
        @(negedge clk);
        // 1: reset, idle, then a held start key
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(50);
        check("idle_estado", 32'(estado), 32'd0);
        key_start_n = 1'b0;
        ev_cnt = 0;
        cycles(D + 4);
        check("start_not_yet", 32'(estado), 32'd0);
        step();
        check("start_latency", 32'(estado), 32'd1);
        check("start_evento", 32'(evento), 32'd1);
        step();
        check("evento_one_cycle", 32'(evento), 32'd0);
        cycles(25);
        check("held_one_press", 32'(ev_cnt), 32'd1);
        key_start_n = 1'b1;
        cycles(10);

        // 2: short glitches are filtered, bouncing then stable low gives one press
        reset_pulse();
        cycles(3);
        for (int len = 1; len <= 3; len++) begin
            key_start_n = 1'b0; cycles(len);
            key_start_n = 1'b1; cycles(3);
        end
        cycles(10);
        check("glitch_estado", 32'(estado), 32'd0);
        ev_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_start_n = 1'b0;
        cycles(15);
        key_start_n = 1'b1;
        cycles(10);
        check("bounce_one_change", 32'(ev_cnt), 32'd1);
        check("bounce_estado", 32'(estado), 32'd1);

        // 3: lap capture and CONGELA timeout
        num_total = 15'd1234;
        press_keys(3'b010);
        check("lap_estado", 32'(estado), 32'd2);
        check("lap_value", 32'(parcial), 32'd1234);
        check("lap_valid", 32'(parcial_valido), 32'd1);
        num_total = 15'd77;
        cycles(15);
        check("timeout_estado", 32'(estado), 32'd1);
        check("lap_kept", 32'(parcial), 32'd1234);

        // 4: coincident presses
        press_keys(3'b111);
        check("prio_zera_estado", 32'(estado), 32'd0);
        check("prio_zera_parcial", 32'(parcial), 32'd0);
        check("prio_zera_valid", 32'(parcial_valido), 32'd0);
        press_keys(3'b001);
        press_keys(3'b011);
        check("prio_start_estado", 32'(estado), 32'd3);
        check("prio_start_nocap", 32'(parcial_valido), 32'd0);

        // 5: full mode tour, then parcial ignored in PARADO
        reset_pulse();
        cycles(3);
        ev_cnt = 0;
        num_total = 15'd4321;
        press_keys(3'b001);
        press_keys(3'b001);
        press_keys(3'b001);
        press_keys(3'b010);
        press_keys(3'b010);
        check("tour_estado", 32'(estado), 32'd1);
        check("tour_events", 32'(ev_cnt), 32'd5);
        press_keys(3'b001);
        press_keys(3'b010);
        check("parado_ignore", 32'(estado), 32'd3);
        check("parado_lap", 32'(parcial), 32'd4321);

        // 6: reset mid-debounce, then key still held yields one press
        reset_pulse();
        cycles(3);
        key_start_n = 1'b0;
        cycles(3);
        rst_n = 1'b0;
        step();
        check("rst_mid_estado", 32'(estado), 32'd0);
        rst_n = 1'b1;
        ev_cnt = 0;
        cycles(D + 10);
        check("after_rst_press", 32'(estado), 32'd1);
        check("after_rst_events", 32'(ev_cnt), 32'd1);
        key_start_n = 1'b1;
        cycles(8);
        press_keys(3'b010);
        rst_n = 1'b0;
        step();
        check("rst_congela_estado", 32'(estado), 32'd0);
        check("rst_congela_valid", 32'(parcial_valido), 32'd0);
        rst_n = 1'b1;
        cycles(5);

        // 7: randomised key traffic against the model
        for (int b = 0; b < 3; b++) begin
            hold[b] = 0;
            kv[b] = 1'b1;
        end
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    kv[b] = ~kv[b];
                    hold[b] = (b == 2 && kv[b] == 1'b1) ? int'($urandom_range(20, 120))
                                                          : int'($urandom_range(1, 40));
                end
                hold[b]--;
            end
            key_start_n   = kv[0];
            key_parcial_n = kv[1];
            key_zera_n    = kv[2];
            num_total     = 15'($urandom_range(0, 32767));
            rst_n         = ($urandom_range(0, 699) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_controle_cronometro
`default_nettype wire
